// File: rtl/tick_gen_pkg.sv
// Shared constants and types for the tick_gen programmable tick/square divider.
package tick_gen_pkg;

    localparam logic MODE_PULSE  = 1'b0;
    localparam logic MODE_SQUARE = 1'b1;

    // Per-channel limit write after channel decode.
    typedef struct packed {
        logic hit;
        logic last;
    } lim_wr_flag_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_chan.sv
// One divider channel: counter, active/shadow limits, pending flag, tick and square outputs.
module tick_chan
    import tick_gen_pkg::*;
#(
    parameter int                BITLEN  = 8,
    parameter logic [BITLEN-1:0] DEF_LIM = {BITLEN{1'b1}}
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              en,
    input  logic              mode,
    input  logic              restart,
    input  logic              wr,
    input  logic [BITLEN-1:0] lim_in,
    output logic              tick,
    output logic              sq,
    output logic              pend,
    output logic [BITLEN-1:0] cnt
);

    logic [BITLEN-1:0] act_lim;
    logic [BITLEN-1:0] shd_lim;
    logic              wrap;

    // >= rather than == so a limit lowered below cnt wraps at once instead of running to 2^BITLEN.
    assign wrap = (cnt >= act_lim);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt     <= '0;
            act_lim <= DEF_LIM;
            shd_lim <= DEF_LIM;
            tick    <= 1'b0;
            sq      <= 1'b0;
            pend    <= 1'b0;
        end else begin
            if (wr)
                shd_lim <= lim_in;
            tick <= 1'b0;
            if (restart) begin
                cnt     <= '0;
                sq      <= 1'b0;
                act_lim <= shd_lim;
                pend    <= wr;
            end else if (!en) begin
                act_lim <= shd_lim;
                pend    <= wr;
            end else if (wrap) begin
                cnt     <= '0;
                act_lim <= shd_lim;
                pend    <= wr;
                tick    <= 1'b1;
                sq      <= (mode == MODE_SQUARE) ? ~sq : 1'b0;
            end else begin
                cnt  <= cnt + BITLEN'(1);
                pend <= pend | wr;
            end
        end
    end

endmodule

// File: rtl/tick_gen.sv
// Multi-channel tick generator: limit-write decode, channel array and count packing.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int                NCH     = 4,
    parameter int                BITLEN  = 8,
    parameter logic [BITLEN-1:0] DEF_LIM = {BITLEN{1'b1}},
    localparam int               SELW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [NCH-1:0]        en,
    input  logic [NCH-1:0]        mode,
    input  logic                  restart,
    input  logic                  lim_wr,
    input  logic [SELW-1:0]       lim_sel,
    input  logic [BITLEN-1:0]     lim_in,
    output logic [NCH-1:0]        tick,
    output logic [NCH-1:0]        sq,
    output logic [NCH-1:0]        pend,
    output logic [NCH*BITLEN-1:0] cnt_out
);

    logic [NCH-1:0]             wr_hit;
    logic [NCH-1:0][BITLEN-1:0] cnt_w;

    // Selects beyond NCH-1 match no channel and are dropped.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NCH; i++)
            wr_hit[i] = lim_wr && (lim_sel == SELW'(i));
    end

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_ch
            tick_chan #(
                .BITLEN  (BITLEN),
                .DEF_LIM (DEF_LIM)
            ) u_chan (
                .clk     (clk),
                .n_rst   (n_rst),
                .en      (en[g]),
                .mode    (mode[g]),
                .restart (restart),
                .wr      (wr_hit[g]),
                .lim_in  (lim_in),
                .tick    (tick[g]),
                .sq      (sq[g]),
                .pend    (pend[g]),
                .cnt     (cnt_w[g])
            );
        end
    endgenerate

    // Packed array flattens channel i onto bits [i*BITLEN +: BITLEN].
    assign cnt_out = cnt_w;

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_tick_gen;

    localparam int NCH    = 4;
    localparam int BITLEN = 8;

    logic                  clk = 1'b0;
    logic                  n_rst;
    logic [NCH-1:0]        en, mode, tick, sq, pend;
    logic                  restart, lim_wr;
    logic [1:0]            lim_sel;
    logic [BITLEN-1:0]     lim_in;
    logic [NCH*BITLEN-1:0] cnt_out;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 0;

    tick_gen #(.NCH(NCH), .BITLEN(BITLEN), .DEF_LIM(8'd255)) dut (
        .clk(clk), .n_rst(n_rst), .en(en), .mode(mode), .restart(restart),
        .lim_wr(lim_wr), .lim_sel(lim_sel), .lim_in(lim_in),
        .tick(tick), .sq(sq), .pend(pend), .cnt_out(cnt_out)
    );

    always #5 clk = ~clk;

    // Behavioural model: integer state per channel, advanced by the rules on each rising edge.
    int m_cnt[NCH], m_act[NCH], m_shd[NCH];
    bit m_tick[NCH], m_sq[NCH], m_pend[NCH];

    always @(posedge clk) begin
        int old_shd;
        bit w;
        for (int i = 0; i < NCH; i++) begin
            w = lim_wr && (int'(lim_sel) == i);
            old_shd = m_shd[i];
            if (!n_rst) begin
                m_cnt[i] = 0; m_act[i] = 255; m_shd[i] = 255;
                m_tick[i] = 0; m_sq[i] = 0; m_pend[i] = 0;
            end else begin
                m_tick[i] = 0;
                if (restart) begin
                    m_cnt[i] = 0; m_sq[i] = 0; m_act[i] = old_shd; m_pend[i] = w;
                end else if (!en[i]) begin
                    m_act[i] = old_shd; m_pend[i] = w;
                end else if (m_cnt[i] >= m_act[i]) begin
                    m_cnt[i] = 0; m_act[i] = old_shd; m_pend[i] = w; m_tick[i] = 1;
                    m_sq[i] = mode[i] ? !m_sq[i] : 1'b0;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                    m_pend[i] = m_pend[i] | w;
                end
                if (w) m_shd[i] = int'(lim_in);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge once checking is armed.
    always @(negedge clk) begin
        logic [NCH-1:0]        et, es, ep;
        logic [NCH*BITLEN-1:0] ec;
        if (chk_on) begin
            for (int i = 0; i < NCH; i++) begin
                et[i] = m_tick[i]; es[i] = m_sq[i]; ep[i] = m_pend[i];
                ec[i*BITLEN +: BITLEN] = m_cnt[i][BITLEN-1:0];
            end
            chk("model_tick", 32'(tick), 32'(et));
            chk("model_sq", 32'(sq), 32'(es));
            chk("model_pend", 32'(pend), 32'(ep));
            chk("model_cnt", cnt_out, ec);
        end
    end

    task automatic next();
        @(negedge clk);
        #1;
    endtask

    function automatic int cnt_of(input int ch);
        return int'(cnt_out[ch*BITLEN +: BITLEN]);
    endfunction

    task automatic wr(input int s, input int v);
        lim_wr = 1'b1; lim_sel = 2'(s); lim_in = 8'(v);
        next();
        lim_wr = 1'b0;
    endtask

    task automatic wait_tick(input int ch, input int maxc, output int n);
        n = 0;
        do begin next(); n++; end while (!tick[ch] && n < maxc);
        if (!tick[ch]) chk("wait_tick_timeout", 32'(n), 32'(0));
    endtask

    task automatic wait_cnt(input int ch, input int v, input int maxc);
        int n = 0;
        while (cnt_of(ch) != v && n < maxc) begin next(); n++; end
        if (cnt_of(ch) != v) chk("wait_cnt_timeout", 32'(cnt_of(ch)), 32'(v));
    endtask

    initial begin
        int n, c, ticks, togs, bad, last;
        logic prev;
        n_rst = 0; en = '0; mode = '0; restart = 0; lim_wr = 0; lim_sel = '0; lim_in = '0;
        next();
        chk_on = 1;
        next();
        n_rst = 1;
        chk("rst_cnt", cnt_out, 32'h0);
        chk("rst_flags", {tick, sq, pend}, 32'h0);

        // ch0 pulse, limit 3
        wr(0, 3);
        chk("pend_set", 32'(pend[0]), 32'd1);
        next();
        chk("pend_clr_dis", 32'(pend[0]), 32'd0);
        en[0] = 1'b1;
        wait_tick(0, 20, n);
        chk("first_tick_lat", 32'(n), 32'd4);
        ticks = 0;
        for (int k = 0; k < 12; k++) begin next(); if (tick[0]) ticks++; end
        chk("ch0_ticks_12", 32'(ticks), 32'd3);

        // ch1 square, limit 4
        wr(1, 4);
        next();
        en[1] = 1'b1; mode[1] = 1'b1;
        prev = sq[1]; ticks = 0; togs = 0; bad = 0; last = 0;
        for (c = 1; c <= 20; c++) begin
            next();
            if (tick[1]) ticks++;
            if (sq[1] != prev) begin
                togs++;
                if (!tick[1]) bad++;
                if (last > 0 && c - last != 5) bad++;
                last = c;
            end
            prev = sq[1];
        end
        chk("sq_ticks", 32'(ticks), 32'd4);
        chk("sq_toggles", 32'(togs), 32'd4);
        chk("sq_align", 32'(bad), 32'd0);

        // ch0 shadow update mid-period
        wr(0, 9);
        wait_tick(0, 20, n);
        chk("lim9_loaded", 32'(pend[0]), 32'd0);
        wait_cnt(0, 3, 20);
        wr(0, 2);
        chk("pend_mid", 32'(pend[0]), 32'd1);
        wait_tick(0, 20, n);
        chk("wrap_at_9", 32'(n), 32'd6);
        chk("pend_after_wrap", 32'(pend[0]), 32'd0);
        wait_tick(0, 20, n);
        chk("period3", 32'(n), 32'd3);
        wait_cnt(0, 2, 10);
        wr(0, 5);
        chk("wrap_edge_tick", 32'(tick[0]), 32'd1);
        chk("wrap_edge_pend", 32'(pend[0]), 32'd1);

        // ch2 disable / lower limit / re-enable
        wr(2, 9);
        next();
        en[2] = 1'b1;
        wait_cnt(2, 7, 20);
        en[2] = 1'b0;
        wr(2, 2);
        next();
        chk("held_cnt", 32'(cnt_of(2)), 32'd7);
        chk("dis_pend_clr", 32'(pend[2]), 32'd0);
        en[2] = 1'b1;
        next();
        chk("reenable_wrap", 32'(tick[2]), 32'd1);
        chk("reenable_cnt", 32'(cnt_of(2)), 32'd0);
        wait_tick(2, 20, n);
        chk("reenable_period", 32'(n), 32'd3);
        wr(2, 0);
        wait_tick(2, 20, n);
        ticks = 0;
        for (int k = 0; k < 5; k++) begin next(); if (tick[2]) ticks++; end
        chk("lim0_held", 32'(ticks), 32'd5);

        // restart aligns all channels
        for (int s = 0; s < NCH; s++) wr(s, 3);
        en = 4'hf; restart = 1'b1;
        next();
        restart = 1'b0;
        chk("restart_cnt", cnt_out, 32'h0);
        chk("restart_flags", {tick, sq, pend}, 32'h0);
        next(); next(); next();
        chk("restart_no_tick", 32'(tick), 32'h0);
        next();
        chk("restart_aligned", 32'(tick), 32'hf);

        // reset mid-period
        next(); next();
        n_rst = 1'b0;
        next();
        n_rst = 1'b1;
        chk("mid_rst_cnt", cnt_out, 32'h0);
        chk("mid_rst_flags", {tick, sq, pend}, 32'h0);
        ticks = 0;
        for (int k = 0; k < 10; k++) begin next(); if (tick != 0) ticks++; end
        chk("def_lim_no_tick", 32'(ticks), 32'd0);
        chk("def_lim_cnt", 32'(cnt_of(0)), 32'd10);

        // randomized traffic, checked by the model every cycle
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) en = 4'($urandom);
            if ($urandom_range(0, 15) == 0) mode = 4'($urandom);
            restart = ($urandom_range(0, 63) == 0);
            lim_wr  = ($urandom_range(0, 5) == 0);
            lim_sel = 2'($urandom);
            lim_in  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            n_rst   = ($urandom_range(0, 199) != 0);
            next();
        end
        n_rst = 1'b1; restart = 1'b0; lim_wr = 1'b0;
        next();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
